msg_bus: RTL

- Coherence message interconnect directly downstream of every cache's message controller.
- Arbitrates the per-cache outbound message requests round-robin and accepts one message at a time.
- Delivers each accepted message to its destination(s): broadcast for snoop requests, unicast for acks.
- Each destination's response input (valid + message) is driven from this block.

---
 rtl/msg_bus_if.sv | 30 +++
 rtl/msg_bus.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/msg_bus_if.sv
// Coherence message bus interface: per-cache request/grant toward the bus,
// shared message plus per-cache valid/ready toward the caches, and status.
interface msg_bus_if #(
    parameter int CACHE_NUM = 4
);
    localparam int ID_W  = $clog2(CACHE_NUM);
    localparam int MSG_W = 4 + 2 * ID_W;

    logic [CACHE_NUM-1:0]       src_req;
    logic [CACHE_NUM*MSG_W-1:0] src_msg;
    logic [CACHE_NUM-1:0]       src_gnt;
    logic [CACHE_NUM-1:0]       dst_valid;
    logic [MSG_W-1:0]           dst_msg;
    logic [CACHE_NUM-1:0]       dst_ready;
    logic                       busy;
    logic                       route_err;
    logic                       timeout_err;

    // cache side
    modport master (
        output src_req, src_msg, dst_ready,
        input  src_gnt, dst_valid, dst_msg, busy, route_err, timeout_err
    );

    // interconnect side
    modport slave (
        input  src_req, src_msg, dst_ready,
        output src_gnt, dst_valid, dst_msg, busy, route_err, timeout_err
    );
endinterface

// File: rtl/msg_bus.sv
// Round-robin coherence message interconnect: one message in flight, broadcast
// for wr_req/rd_req, unicast otherwise. Optional watchdog: MSG_BUS_TIMEOUT_EN.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | arbitrate src_req, capture winner's message and destination set
//  DELIVER | present dst_valid = pending until every destination handshakes
module msg_bus #(
    parameter int CACHE_NUM   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic     clk,
    input  logic     rst,
    msg_bus_if.slave bus
);
    localparam int ID_W  = $clog2(CACHE_NUM);
    localparam int MSG_W = 4 + 2 * ID_W;
    localparam logic [3:0] MSG_WR_REQ = 4'b0100;
    localparam logic [3:0] MSG_RD_REQ = 4'b0101;

    if (CACHE_NUM < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("msg_bus: CACHE_NUM and TIMEOUT_CYC must both be >= 2");
    end

    typedef enum logic {IDLE, DELIVER} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CACHE_NUM-1:0] pending_q, pending_d;
    logic [MSG_W-1:0]     dst_msg_q, dst_msg_d;
    logic                 route_err_q, route_err_d;
    logic                 timeout_err_q, timeout_err_d;

    logic                 gnt_found;
    logic [ID_W-1:0]      winner;
    logic [3:0]           win_code;
    logic [ID_W-1:0]      win_ra;
    logic                 timeout_hit;

    always_comb begin
        logic [ID_W:0] cand;
        gnt_found = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 0; k < CACHE_NUM; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(CACHE_NUM)) cand = cand - (ID_W+1)'(CACHE_NUM);
            if (!gnt_found && bus.src_req[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                winner    = cand[ID_W-1:0];
            end
        end
    end

    assign win_code = bus.src_msg[winner*MSG_W + MSG_W - 4 +: 4];
    assign win_ra   = bus.src_msg[winner*MSG_W +: ID_W];

`ifdef MSG_BUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_d;

    // held at zero in IDLE, so the first DELIVER cycle always sees 0
    always_comb begin
        wd_d = '0;
        if (state_q == DELIVER) wd_d = wd_q + 1'b1;
    end

    assign timeout_hit = (state_q == DELIVER) && (pending_q != '0) &&
                         (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        pending_d     = pending_q;
        dst_msg_d     = dst_msg_q;
        route_err_d   = route_err_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    rr_ptr_d  = (winner == ID_W'(CACHE_NUM - 1)) ? '0 : winner + 1'b1;
                    dst_msg_d = bus.src_msg[winner*MSG_W +: MSG_W];
                    if (win_code == MSG_WR_REQ || win_code == MSG_RD_REQ) begin
                        pending_d = ~(CACHE_NUM'(1) << winner);
                        state_d   = DELIVER;
                    end else if ({1'b0, win_ra} >= (ID_W+1)'(CACHE_NUM)) begin
                        // unroutable: grant completes, message is dropped
                        pending_d   = '0;
                        route_err_d = 1'b1;
                    end else begin
                        pending_d = CACHE_NUM'(1) << win_ra;
                        state_d   = DELIVER;
                    end
                end
            end
            DELIVER: begin
                pending_d = pending_q & ~bus.dst_ready;
                if (timeout_hit) begin
                    pending_d     = '0;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (pending_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            pending_q     <= '0;
            dst_msg_q     <= '0;
            route_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            pending_q     <= pending_d;
            dst_msg_q     <= dst_msg_d;
            route_err_q   <= route_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // grant is combinational, so it must be masked by reset explicitly
    assign bus.src_gnt     = (state_q == IDLE && gnt_found && !rst) ?
                             (CACHE_NUM'(1) << winner) : '0;
    assign bus.dst_valid   = (state_q == DELIVER) ? pending_q : '0;
    assign bus.dst_msg     = dst_msg_q;
    assign bus.busy        = (state_q == DELIVER);
    assign bus.route_err   = route_err_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
